// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: multi-digit packed-BCD adder/subtractor, one decimal
// digit per clock, least-significant digit first. Subtraction uses ten's
// complement (a + (9..9 - b) + 1), so finalcarry=1 means "no borrow".
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, sub      request (sampled in IDLE only), 0:a+b 1:a-b
//   a, b            packed BCD operands, digit 0 in bits [3:0]
//   busy            state != IDLE
//   done            one-cycle pulse, results valid from this cycle
//   sum             packed BCD result (held until next done or rst)
//   finalcarry      decimal carry out / not-borrow (held)
//   invalid         some operand digit was > 9 (held)
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  finalcarry,
  output logic                  invalid
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r, shadow, shadow_nx;
  logic            sub_r, carry;
  logic [IW-1:0]   idx;

  logic            bad;
  logic [3:0]      a_dig, b_dig, bd, dig;
  logic [4:0]      t;
  logic            gt9, last;

  // Operand screen: any nibble above 9 in either input.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad = 1'b1;
    end
  end

  // One-digit datapath on the latched operands.
  always_comb begin
    a_dig = a_r[4*int'(idx) +: 4];
    b_dig = b_r[4*int'(idx) +: 4];
    bd    = sub_r ? (4'd9 - b_dig) : b_dig;
    t     = {1'b0, a_dig} + {1'b0, bd} + {4'b0, carry};
    gt9   = (t > 5'd9);
    // +6 mod 16 skips the six unused codes; only the low nibble is kept.
    dig   = gt9 ? (t[3:0] + 4'd6) : t[3:0];
    last  = (idx == IW'(DIGITS - 1));
    shadow_nx = shadow;
    shadow_nx[4*int'(idx) +: 4] = dig;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE:    if (start) state_nx = bad ? DONE : RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Visible results are loaded on the edge that enters DONE so they are
  // valid during the done cycle and untouched while a new run is going.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      sub_r      <= 1'b0;
      idx        <= '0;
      carry      <= 1'b0;
      shadow     <= '0;
      sum        <= '0;
      finalcarry <= 1'b0;
      invalid    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            idx   <= '0;
            if (bad) begin
              carry      <= 1'b0;
              sum        <= '0;
              finalcarry <= 1'b0;
              invalid    <= 1'b1;
            end else begin
              carry <= sub;  // the +1 of ten's complement
            end
          end
        end
        RUN: begin
          shadow <= shadow_nx;
          carry  <= gt9;
          idx    <= idx + 1'b1;
          if (last) begin
            sum        <= shadow_nx;
            finalcarry <= gt9;
            invalid    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
